// File: rtl/bwd_seq_pkg.sv
// Shared definitions for the backward-layer sequencer: state encoding,
// default geometry and the counter-width helper.
package bwd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4,
    FIN    = 3'd5
  } state_e;

  localparam int NUM_UNKNOWNS_DEF = 2;
  localparam int NUM_NONLIN_DEF   = 1;
  localparam int BIT_WIDTH_DEF    = 32;
  localparam int EXTRA_BITS_DEF   = 2;
  localparam int MAC_LAT_DEF      = 1;
  localparam int NUM_PASSES_DEF   = 16;

  localparam int N = NUM_UNKNOWNS_DEF + NUM_NONLIN_DEF;
  localparam int W = BIT_WIDTH_DEF + EXTRA_BITS_DEF;

  // Width of a counter holding 0..modulus-1; never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  localparam int BEAT_W = cnt_width(N);
  localparam int PASS_W = cnt_width(NUM_PASSES_DEF + 1);

endpackage

// File: rtl/bwd_beat_counter.sv
// Modulo-MODULUS up-counter with enable, synchronous clear and a
// terminal-count flag; used for beat/shift indexing and the settle delay.
module bwd_beat_counter #(
  parameter int MODULUS = 3,
  parameter int WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(MODULUS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/bwd_layer_sequencer.sv
// Sequences one backward linear layer: handshaked scaler intake with
// per-beat accumulate enables, MAC settle delay, and back-pressured drain.
module bwd_layer_sequencer
  import bwd_seq_pkg::*;
#(
  parameter int NUM_UNKNOWNS = NUM_UNKNOWNS_DEF,
  parameter int NUM_NONLIN   = NUM_NONLIN_DEF,
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int EXTRA_BITS   = EXTRA_BITS_DEF,
  parameter int MAC_LAT      = MAC_LAT_DEF,
  parameter int NUM_PASSES   = NUM_PASSES_DEF,
  localparam int NB = NUM_UNKNOWNS + NUM_NONLIN,
  localparam int DW = BIT_WIDTH + EXTRA_BITS,
  localparam int BW = cnt_width(NB),
  localparam int PW = cnt_width(NUM_PASSES + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [DW-1:0] IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [DW-1:0] SCALER_OUT,
  output logic          LAYER_CLR,
  output logic          LAYER_ACC_EN,
  output logic          SHIFT_VALID,
  input  logic          OUT_READY,
  output logic [BW-1:0] BEAT_IDX,
  output logic [PW-1:0] PASS_CNT,
  output logic          BUSY,
  output logic          DONE
);

  localparam int SW = cnt_width(MAC_LAT);

  state_e          state_q, state_d;
  logic            in_xfer, out_xfer;
  logic            acc_en_q;
  logic [DW-1:0]   scaler_q;
  logic [PW-1:0]   pass_q;
  logic            beat_tc;
  logic            settle_en, settle_tc;
  logic [SW-1:0]   unused_settle_cnt;

  assign in_xfer  = IN_VALID  && (state_q == ACCUM);
  assign out_xfer = OUT_READY && (state_q == DRAIN);

  // Shared index: counts accepted scalers in ACCUM, shifted words in DRAIN.
  bwd_beat_counter #(.MODULUS(NB), .WIDTH(BW)) u_beat (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (state_q == CLEAR),
    .en    (in_xfer || out_xfer),
    .count (BEAT_IDX),
    .tc    (beat_tc)
  );

  // The first SETTLE cycle carries the final ACC_EN pulse; the MAC latency
  // is counted from the cycle after it.
  assign settle_en = (state_q == SETTLE) && !acc_en_q;

  bwd_beat_counter #(.MODULUS(MAC_LAT), .WIDTH(SW)) u_settle (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (state_q != SETTLE),
    .en    (settle_en),
    .count (unused_settle_cnt),
    .tc    (settle_tc)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    IN_READY    = 1'b0;
    LAYER_CLR   = 1'b0;
    SHIFT_VALID = 1'b0;
    BUSY        = 1'b1;
    DONE        = 1'b0;
    case (state_q)
      IDLE: begin
        LAYER_CLR = 1'b1;
        BUSY      = 1'b0;
        if (START) state_d = CLEAR;
      end
      CLEAR: begin
        LAYER_CLR = 1'b1;
        state_d   = ACCUM;
      end
      ACCUM: begin
        IN_READY = 1'b1;
        if (in_xfer && beat_tc) state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_en && settle_tc) state_d = DRAIN;
      end
      DRAIN: begin
        SHIFT_VALID = 1'b1;
        if (out_xfer && beat_tc) begin
          state_d = (pass_q == PW'(NUM_PASSES - 1)) ? FIN : CLEAR;
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc_en_q <= 1'b0;
      scaler_q <= '0;
      pass_q   <= '0;
    end else begin
      acc_en_q <= in_xfer;
      if (in_xfer) scaler_q <= IN_DATA;
      if (state_q == IDLE && START) begin
        pass_q <= '0;
      end else if (out_xfer && beat_tc) begin
        pass_q <= pass_q + 1'b1;
      end
    end
  end

  assign LAYER_ACC_EN = acc_en_q;
  assign SCALER_OUT   = scaler_q;
  assign PASS_CNT     = pass_q;

endmodule

// File: tb/tb_bwd_layer_sequencer.sv
// Randomized bench for bwd_layer_sequencer: a transaction-level model
// predicts every output each cycle and feeds scoreboards for scalers and words.
module tb_bwd_layer_sequencer;
  import bwd_seq_pkg::*;

  localparam int NU = 2;
  localparam int NN = 1;
  localparam int BWD = 32;
  localparam int EB = 2;
  localparam int ML = 1;
  localparam int NP = 2;
  localparam int NB = NU + NN;
  localparam int DW = BWD + EB;
  localparam int BW = cnt_width(NB);
  localparam int PW = cnt_width(NP + 1);

  logic          clk, rst_n, start;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] scaler_out;
  logic          layer_clr, layer_acc_en, shift_valid, out_ready;
  logic [BW-1:0] beat_idx;
  logic [PW-1:0] pass_cnt;
  logic          busy, done;

  bwd_layer_sequencer #(
    .NUM_UNKNOWNS(NU), .NUM_NONLIN(NN), .BIT_WIDTH(BWD),
    .EXTRA_BITS(EB), .MAC_LAT(ML), .NUM_PASSES(NP)
  ) dut (
    .CLK(clk), .RESET(rst_n), .START(start),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SCALER_OUT(scaler_out), .LAYER_CLR(layer_clr), .LAYER_ACC_EN(layer_acc_en),
    .SHIFT_VALID(shift_valid), .OUT_READY(out_ready),
    .BEAT_IDX(beat_idx), .PASS_CNT(pass_cnt), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: pass-level bookkeeping with event timestamps.
  bit            m_active = 0;
  int            m_pass = 0, m_acc = 0, m_drn = 0;
  int            last_xfer = -10, clear_cyc = -10, done_cyc = -10;
  logic [DW-1:0] m_scaler = '0, last_data = '0;
  logic [DW-1:0] scal_q[$];
  int            word_q[$];

  always @(negedge clk) begin
    logic e_busy, e_clr, e_ir, e_acc, e_sv, e_done;
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_pass = 0; m_acc = 0; m_drn = 0;
      last_xfer = -10; clear_cyc = -10; done_cyc = -10;
      m_scaler = '0;
      scal_q.delete();
      word_q.delete();
    end
    if (cyc == last_xfer + 1) m_scaler = last_data;

    e_busy = m_active;
    e_clr  = !m_active || (cyc == clear_cyc);
    e_ir   = m_active && (cyc > clear_cyc) && (m_acc < NB);
    e_acc  = (cyc == last_xfer + 1);
    e_sv   = m_active && (m_acc == NB) && (cyc >= last_xfer + 2 + ML) && (m_drn < NB);
    e_done = (cyc == done_cyc);

    check("busy", busy, e_busy);
    check("layer_clr", layer_clr, e_clr);
    check("in_ready", in_ready, e_ir);
    check("layer_acc_en", layer_acc_en, e_acc);
    check("shift_valid", shift_valid, e_sv);
    check("done", done, e_done);
    check("beat_idx", beat_idx, (m_acc + m_drn) % NB);
    check("pass_cnt", pass_cnt, m_pass);
    check("scaler_out", scaler_out, m_scaler);

    if (rst_n) begin
      if (!m_active && start) begin
        m_active = 1; m_pass = 0; m_acc = 0; m_drn = 0;
        clear_cyc = cyc + 1;
      end
      if (e_ir && in_valid) begin
        last_xfer = cyc;
        last_data = in_data;
        m_acc++;
        scal_q.push_back(in_data);
      end
      if (e_sv && out_ready) begin
        word_q.push_back(m_drn);
        m_drn++;
        if (m_drn == NB) begin
          m_pass++;
          if (m_pass == NP) done_cyc = cyc + 1;
          else begin
            clear_cyc = cyc + 1; m_acc = 0; m_drn = 0;
          end
        end
      end
      if (cyc == done_cyc) m_active = 0;
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents an output event.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (layer_acc_en) begin
        if (scal_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL acc_en_spurious: got pulse, expected none (cycle %0d)", cyc);
        end else check("scaler_at_acc_en", scaler_out, scal_q.pop_front());
      end
      if (shift_valid && out_ready) begin
        if (word_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL word_spurious: got word idx %0d, expected none (cycle %0d)", beat_idx, cyc);
        end else check("word_beat_idx", beat_idx, word_q.pop_front());
      end
    end
  end

  logic [DW-1:0] flt_tbl[6];
  logic [5:0]    bubble_pat = 6'b101001;
  int            sent = 0;
  int            stall_cnt = 0;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom_range(0, 3) == 0 ? 2'b00 : 2'b01, 32'($urandom)};
  endfunction

  task automatic drive_cycle(input int mode, input int k);
    case (mode)
      0: begin
        in_valid  = 1'b1;
        in_data   = flt_tbl[sent % 6];
        out_ready = 1'b1;
      end
      1: begin
        in_valid = bubble_pat[k % 6];
        in_data  = rand_data();
        if (shift_valid && beat_idx == BW'(1) && stall_cnt < 4) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else out_ready = 1'b1;
      end
      default: begin
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = rand_data();
        out_ready = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic do_run(input int mode);
    bit finished;
    finished  = 0;
    stall_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 400 && !finished; k++) begin
      drive_cycle(mode, k);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) begin
        if (mode == 1)      start = shift_valid || done;
        else if (mode == 2) start = ($urandom_range(0, 3) == 0);
      end else finished = 1;
    end
    check("run_completes", finished, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    flt_tbl[0] = {2'b01, 32'h3f80_0000};
    flt_tbl[1] = {2'b01, 32'h4000_0000};
    flt_tbl[2] = {2'b01, 32'h4040_0000};
    flt_tbl[3] = {2'b01, 32'h4080_0000};
    flt_tbl[4] = {2'b01, 32'h40a0_0000};
    flt_tbl[5] = {2'b01, 32'h40c0_0000};
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Valid data offered while idle must not be consumed.
    in_valid = 1'b1;
    in_data  = flt_tbl[0];
    repeat (3) @(posedge clk);
    #1;

    do_run(0);
    repeat (2) @(posedge clk);
    do_run(1);
    repeat (2) @(posedge clk);

    // Asynchronous abort mid-ACCUM after the first accepted beat.
    #1 start = 1'b1; in_valid = 1'b1; in_data = rand_data();
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 20 && beat_idx != BW'(1); k++) begin
      @(posedge clk); #1;
    end
    check("reset_reached_beat1", beat_idx, 1);
    rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_layer_clr", layer_clr, 1);
    check("reset_in_ready", in_ready, 0);
    check("reset_done", done, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_run(0);
    for (int r = 0; r < 6; r++) do_run(2);
    repeat (4) @(posedge clk);
    #3;
    check("scalers_left", scal_q.size(), 0);
    check("words_left", word_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
